// File: rtl/cmp_mon_pkg.sv
// Shared constants and types for cmp_result_monitor: result codes, event codes, FSM states.
package cmp_mon_pkg;

    localparam logic [2:0] R_GT = 3'b100;
    localparam logic [2:0] R_EQ = 3'b010;
    localparam logic [2:0] R_LT = 3'b001;

    typedef enum logic [1:0] {
        EV_L = 2'b00,
        EV_E = 2'b01,
        EV_G = 2'b10
    } ev_code_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIRE
    } state_t;

    function automatic logic is_legal(input logic [2:0] r);
        return (r == R_GT) || (r == R_EQ) || (r == R_LT);
    endfunction

    function automatic ev_code_t to_ev(input logic [2:0] r);
        ev_code_t c;
        c = EV_L;
        if (r == R_GT) c = EV_G;
        else if (r == R_EQ) c = EV_E;
        return c;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (inc && (q_q != '1)) begin
            q_d = q_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q_q <= '0;
        else        q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/cmp_result_monitor.sv
// Comparator result monitor: per-class saturating counts, streak events via a one-entry buffer, sticky illegal-code flag.
// Define CMP_RESULT_MONITOR_TOTAL_EN to add the tot_cnt port (count of all accepted results).
module cmp_result_monitor
    import cmp_mon_pkg::*;
#(
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned STREAK_LEN = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_r,
    input  logic             clr,
    output logic [CNT_W-1:0] g_cnt,
    output logic [CNT_W-1:0] e_cnt,
    output logic [CNT_W-1:0] l_cnt,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [1:0]       ev_code,
`ifdef CMP_RESULT_MONITOR_TOTAL_EN
    output logic [CNT_W+1:0] tot_cnt,
`endif
    output logic             err
);

    state_t   state_q, state_d;
    logic [3:0] run_q, run_d;
    logic [3:0] run_nx;
    ev_code_t cls_q, cls_d;
    ev_code_t ev_code_q, ev_code_d;
    ev_code_t in_cls;
    logic     ev_valid_q, ev_valid_d;
    logic     err_q, err_d;
    logic     acc;
    logic     legal;

    assign in_ready = !ev_valid_q || ev_ready;
    assign acc      = in_valid && in_ready;
    assign legal    = is_legal(in_r);
    assign in_cls   = to_ev(in_r);

    sat_counter #(.W(CNT_W)) u_g_cnt (
        .clk(clk), .rst_n(rst_n), .clr(clr), .inc(acc && (in_r == R_GT)), .q(g_cnt)
    );
    sat_counter #(.W(CNT_W)) u_e_cnt (
        .clk(clk), .rst_n(rst_n), .clr(clr), .inc(acc && (in_r == R_EQ)), .q(e_cnt)
    );
    sat_counter #(.W(CNT_W)) u_l_cnt (
        .clk(clk), .rst_n(rst_n), .clr(clr), .inc(acc && (in_r == R_LT)), .q(l_cnt)
    );
`ifdef CMP_RESULT_MONITOR_TOTAL_EN
    sat_counter #(.W(CNT_W+2)) u_tot_cnt (
        .clk(clk), .rst_n(rst_n), .clr(clr), .inc(acc), .q(tot_cnt)
    );
`endif

    always_comb begin
        state_d    = state_q;
        run_d      = run_q;
        cls_d      = cls_q;
        ev_valid_d = ev_valid_q;
        ev_code_d  = ev_code_q;
        err_d      = err_q;
        run_nx     = 4'd1;

        if (ev_valid_q && ev_ready) ev_valid_d = 1'b0;

        // FIRE waits for a free buffer slot; a result accepted in the same cycle starts a fresh run.
        if ((state_q == FIRE) && in_ready) begin
            ev_valid_d = 1'b1;
            ev_code_d  = cls_q;
            run_d      = '0;
            state_d    = IDLE;
        end

        if (acc) begin
            if (!legal) begin
                err_d   = 1'b1;
                run_d   = '0;
                state_d = IDLE;
            end else begin
                if ((state_q == RUN) && (cls_q == in_cls)) begin
                    run_nx = run_q + 4'd1;
                end else begin
                    cls_d  = in_cls;
                    run_nx = 4'd1;
                end
                run_d   = run_nx;
                state_d = (run_nx == 4'(STREAK_LEN)) ? FIRE : RUN;
            end
        end

        if (clr) begin
            state_d    = IDLE;
            run_d      = '0;
            ev_valid_d = 1'b0;
            err_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            run_q      <= '0;
            cls_q      <= EV_L;
            ev_valid_q <= 1'b0;
            ev_code_q  <= EV_L;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            run_q      <= run_d;
            cls_q      <= cls_d;
            ev_valid_q <= ev_valid_d;
            ev_code_q  <= ev_code_d;
            err_q      <= err_d;
        end
    end

    assign ev_valid = ev_valid_q;
    assign ev_code  = ev_code_q;
    assign err      = err_q;

endmodule

// File: tb/tb_cmp_result_monitor.sv
// Randomised plus directed bench for cmp_result_monitor against a run-length reference model.
module tb_cmp_result_monitor;

    localparam int unsigned CNT_W = 4;
    localparam int unsigned SL    = 4;
    localparam int unsigned CMAX  = (1 << CNT_W) - 1;
    localparam int unsigned TMAX  = (1 << (CNT_W + 2)) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [2:0]       in_r = 3'b000;
    logic             clr = 1'b0;
    logic [CNT_W-1:0] g_cnt, e_cnt, l_cnt;
    logic             ev_valid;
    logic             ev_ready = 1'b0;
    logic [1:0]       ev_code;
    logic             err;
`ifdef CMP_RESULT_MONITOR_TOTAL_EN
    logic [CNT_W+1:0] tot_cnt;
`endif

    cmp_result_monitor #(.CNT_W(CNT_W), .STREAK_LEN(SL)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_r(in_r), .clr(clr), .g_cnt(g_cnt), .e_cnt(e_cnt), .l_cnt(l_cnt),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code),
`ifdef CMP_RESULT_MONITOR_TOTAL_EN
        .tot_cnt(tot_cnt),
`endif
        .err(err)
    );

    always #5 clk = ~clk;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Reference model: counts indexed by event code (0=L, 1=E, 2=G).
    int unsigned m_cnt [3];
    int unsigned m_tot;
    int unsigned m_run;
    int          m_cls;
    bit          m_err;
    bit          m_fp;
    int unsigned m_fcode;
    bit          m_evv;
    int unsigned m_evc;
    int unsigned n_events;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int class_of(input logic [2:0] r);
        case (r)
            3'b100:  return 2;
            3'b010:  return 1;
            3'b001:  return 0;
            default: return -1;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) m_cnt[i] = 0;
        m_tot = 0; m_run = 0; m_cls = -1; m_err = 0;
        m_fp = 0; m_fcode = 0; m_evv = 0; m_evc = 0;
    endtask

    task automatic model_step(input bit acc, input logic [2:0] r, input bit c,
                              input bit rdy, input bit rdy_exp);
        int k;
        if (c) begin
            for (int i = 0; i < 3; i++) m_cnt[i] = 0;
            m_tot = 0; m_run = 0; m_cls = -1; m_err = 0; m_fp = 0; m_evv = 0;
            return;
        end
        if (m_fp && rdy_exp) begin
            m_evv = 1; m_evc = m_fcode; m_fp = 0; n_events++;
        end else if (m_evv && rdy) begin
            m_evv = 0;
        end
        if (!acc) return;
        if (m_tot < TMAX) m_tot++;
        k = class_of(r);
        if (k < 0) begin
            m_err = 1; m_run = 0; m_cls = -1;
        end else begin
            if (m_cnt[k] < CMAX) m_cnt[k]++;
            if (m_run > 0 && m_cls == k) m_run++;
            else begin m_cls = k; m_run = 1; end
            if (m_run == SL) begin
                m_fp = 1; m_fcode = k; m_run = 0; m_cls = -1;
            end
        end
    endtask

    task automatic check_outputs(input bit rdy);
        check("in_ready", in_ready, (!m_evv || rdy) ? 1 : 0);
        check("g_cnt", g_cnt, m_cnt[2]);
        check("e_cnt", e_cnt, m_cnt[1]);
        check("l_cnt", l_cnt, m_cnt[0]);
        check("ev_valid", ev_valid, m_evv);
        check("ev_code", ev_code, m_evc);
        check("err", err, m_err);
`ifdef CMP_RESULT_MONITOR_TOTAL_EN
        check("tot_cnt", tot_cnt, m_tot);
`endif
    endtask

    task automatic cycle(input bit v, input logic [2:0] r, input bit c, input bit rdy);
        bit rdy_exp;
        in_valid = v; in_r = r; clr = c; ev_ready = rdy;
        @(negedge clk);
        check_outputs(rdy);
        rdy_exp = !m_evv || rdy;
        @(posedge clk);
        model_step(v && rdy_exp, r, c, rdy, rdy_exp);
        #1;
    endtask

    task automatic idle(input int unsigned n, input bit rdy);
        for (int unsigned i = 0; i < n; i++) cycle(1'b0, 3'b000, 1'b0, rdy);
    endtask

    initial begin
        logic [2:0] seq2 [8];
        logic [2:0] seq4 [5];
        int unsigned ev_before;
        int          cur;
        logic [2:0]  rr;

        model_reset();
        n_events = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("reset_in_ready", in_ready, 1);
        check_outputs(1'b1);

        // G streak
        for (int i = 0; i < 4; i++) cycle(1'b1, 3'b100, 1'b0, 1'b1);
        idle(3, 1'b1);
        check("g_streak_events", n_events, 1);

        // L streak broken by one E
        cycle(1'b0, 3'b000, 1'b1, 1'b1);
        seq2[0] = 3'b001; seq2[1] = 3'b001; seq2[2] = 3'b001; seq2[3] = 3'b010;
        seq2[4] = 3'b001; seq2[5] = 3'b001; seq2[6] = 3'b001; seq2[7] = 3'b001;
        ev_before = n_events;
        for (int i = 0; i < 8; i++) cycle(1'b1, seq2[i], 1'b0, 1'b1);
        idle(3, 1'b1);
        check("l_streak_events", n_events - ev_before, 1);

        // E streak with back-pressure
        cycle(1'b0, 3'b000, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b1, 3'b010, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b1, 3'b010, 1'b0, 1'b0);
        check("bp_stalled", in_ready, 0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 3'b010, 1'b0, 1'b1);
        idle(4, 1'b1);

        // Illegal code breaks the streak
        cycle(1'b0, 3'b000, 1'b1, 1'b1);
        seq4[0] = 3'b100; seq4[1] = 3'b100; seq4[2] = 3'b110;
        seq4[3] = 3'b100; seq4[4] = 3'b100;
        ev_before = n_events;
        for (int i = 0; i < 5; i++) cycle(1'b1, seq4[i], 1'b0, 1'b1);
        idle(3, 1'b1);
        check("illegal_no_event", n_events - ev_before, 0);
        cycle(1'b1, 3'b111, 1'b1, 1'b1);
        idle(1, 1'b1);

        // Saturation: 20 E results
        ev_before = n_events;
        for (int i = 0; i < 20; i++) cycle(1'b1, 3'b010, 1'b0, 1'b1);
        idle(3, 1'b1);
        check("sat_events", n_events - ev_before, 5);
        check("sat_e_cnt", e_cnt, CMAX);

        // Asynchronous reset mid-run
        cycle(1'b0, 3'b000, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 3'b001, 1'b0, 1'b1);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_l_cnt", l_cnt, 0);
        check("rst_ev_valid", ev_valid, 0);
        check("rst_err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        ev_before = n_events;
        cycle(1'b1, 3'b001, 1'b0, 1'b1);
        idle(4, 1'b1);
        check("rst_no_event", n_events - ev_before, 0);

        // Random traffic
        cur = 0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(3) == 0) cur = int'($urandom_range(2));
            rr = 3'b001 << cur;
            if ($urandom_range(19) == 0) rr = ($urandom_range(1) == 0) ? 3'b000 : 3'b111;
            cycle($urandom_range(3) != 0, rr, $urandom_range(99) == 0, $urandom_range(2) != 0);
        end
        idle(4, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
